// File: rtl/apb_reg_slave.sv
// APB completer: NUM_REGS read/write registers plus read-only write/read/error
// transfer counters, with fixed two-phase timing (no PREADY/PSLVERR).
module apb_reg_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                           apbClk,
   input  logic                           rst,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_strobe
);

   // state  | meaning
   // IDLE   | no transfer in progress
   // SETUP  | address/direction/data latched, waiting for PENABLE
   // ACCESS | transfer committed, master may hold the access phase
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                               state, state_nxt;
   logic [ADDR_WIDTH-1:0]                addr_q;
   logic                                 write_q;
   logic [DATA_WIDTH-1:0]                wdata_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
   logic [DATA_WIDTH-1:0]                wr_cnt, rd_cnt, err_cnt;

   logic                                 latch_en, commit, idle_err;
   logic [ADDR_WIDTH-1:0]                off, idx;
   logic                                 aligned;
   logic [NUM_REGS-1:0]                  rw_hit;
   logic                                 sel_wc, sel_rc, sel_ec, mapped;
   logic [DATA_WIDTH-1:0]                rd_val;
   logic                                 wr_evt, rd_evt, err_evt;

   assign reg_q = regs;

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      idle_err  = 1'b0;
      latch_en  = PSEL & ~PENABLE;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE)      state_nxt = SETUP;
            else if (PSEL && PENABLE)  idle_err  = 1'b1;
         end
         SETUP: begin
            if (!PSEL)                 state_nxt = IDLE;
            else if (PENABLE) begin
               state_nxt = ACCESS;
               commit    = 1'b1;
            end
            else                       state_nxt = SETUP;
         end
         ACCESS: begin
            if (!PSEL)                 state_nxt = IDLE;
            else if (!PENABLE)         state_nxt = SETUP;
         end
         default:                      state_nxt = IDLE;
      endcase
   end

   // Decode always works on the latched setup-phase address, never the live bus.
   always_comb begin
      off     = addr_q - BASE_ADDR;
      idx     = off >> 2;
      aligned = (off[1:0] == 2'b00);
      for (int i = 0; i < NUM_REGS; i++)
         rw_hit[i] = aligned && (idx == ADDR_WIDTH'(i));
      sel_wc = aligned && (idx == ADDR_WIDTH'(NUM_REGS));
      sel_rc = aligned && (idx == ADDR_WIDTH'(NUM_REGS + 1));
      sel_ec = aligned && (idx == ADDR_WIDTH'(NUM_REGS + 2));
      mapped = (|rw_hit) | sel_wc | sel_rc | sel_ec;
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rw_hit[i]) rd_val = regs[i];
      if (sel_wc) rd_val = wr_cnt;
      if (sel_rc) rd_val = rd_cnt;
      if (sel_ec) rd_val = err_cnt;
      wr_evt  = commit & write_q & (|rw_hit);
      rd_evt  = commit & ~write_q & mapped;
      err_evt = idle_err | (commit & (write_q ? ~(|rw_hit) : ~mapped));
   end

   always_ff @(posedge apbClk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         regs      <= '0;
         wr_strobe <= '0;
         PRDATA    <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         err_cnt   <= '0;
      end
      else begin
         state <= state_nxt;
         if (latch_en) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
         end
         wr_strobe <= wr_evt ? rw_hit : '0;
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_evt && rw_hit[i]) regs[i] <= wdata_q;
         // Unmapped reads land here too; rd_val is zero for them.
         if (commit && !write_q) PRDATA <= rd_val;
         if (wr_evt)  wr_cnt  <= wr_cnt + 1'b1;
         if (rd_evt)  rd_cnt  <= rd_cnt + 1'b1;
         if (err_evt) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: directed vector table, reset-mid-transfer sequence and
// randomized bus traffic against a transaction-level reference model.
module tb_apb_reg_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 4;

   logic              apbClk = 1'b0;
   logic              rst;
   logic              PSEL, PENABLE, PWRITE;
   logic [AW-1:0]     PADDR;
   logic [DW-1:0]     PWDATA;
   logic [DW-1:0]     PRDATA;
   logic [NR*DW-1:0]  reg_q;
   logic [NR-1:0]     wr_strobe;

   apb_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR('0)) dut (
      .apbClk(apbClk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .reg_q(reg_q), .wr_strobe(wr_strobe)
   );

   always #5 apbClk = ~apbClk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: bus-transaction view of the slave.
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_wr, m_rd, m_err, m_prdata;
   logic [NR-1:0] m_strobe;
   bit            p_valid, p_active;
   bit            p_w;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_data;

   task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_wr = '0; m_rd = '0; m_err = '0; m_prdata = '0; m_strobe = '0;
      p_valid = 0; p_active = 0; p_w = 0; p_addr = '0; p_data = '0;
   endtask

   // kind: 0 = R/W reg, 1 = WR_COUNT, 2 = RD_COUNT, 3 = ERR_COUNT, 4 = unmapped
   function automatic int decode(input logic [AW-1:0] a, output int idx);
      logic [AW-1:0] off;
      off = a - AW'(0);
      idx = 0;
      if (off % 4 != 0) return 4;
      if (off / 4 < NR) begin
         idx = int'(off / 4);
         return 0;
      end
      if (off / 4 == NR)     return 1;
      if (off / 4 == NR + 1) return 2;
      if (off / 4 == NR + 2) return 3;
      return 4;
   endfunction

   task automatic model_commit();
      int k, idx;
      k = decode(p_addr, idx);
      if (p_w) begin
         if (k == 0) begin
            m_regs[idx] = p_data;
            m_strobe    = NR'(1) << idx;
            m_wr        = m_wr + 1;
         end
         else m_err = m_err + 1;
      end
      else begin
         case (k)
            0: m_prdata = m_regs[idx];
            1: m_prdata = m_wr;
            2: m_prdata = m_rd;
            3: m_prdata = m_err;
            default: m_prdata = '0;
         endcase
         if (k == 4) m_err = m_err + 1;
         else        m_rd  = m_rd + 1;
      end
   endtask

   task automatic model_edge(input bit s, input bit e, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_strobe = '0;
      if (!s) begin
         p_valid = 0; p_active = 0;
      end
      else if (!e) begin
         p_valid = 1; p_active = 0; p_w = w; p_addr = a; p_data = d;
      end
      else if (p_valid) begin
         model_commit();
         p_valid = 0; p_active = 1;
      end
      else if (!p_active) m_err = m_err + 1;
   endtask

   function automatic logic [NR*DW-1:0] model_regq();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
      return v;
   endfunction

   task automatic cyc(input bit s, input bit e, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      PSEL = s; PENABLE = e; PWRITE = w; PADDR = a; PWDATA = d;
      @(posedge apbClk);
      model_edge(s, e, w, a, d);
      #1;
      check("mdl_prdata", NR*DW'(PRDATA), NR*DW'(m_prdata));
      check("mdl_strobe", NR*DW'(wr_strobe), NR*DW'(m_strobe));
      check("mdl_reg_q", reg_q, model_regq());
   endtask

   typedef struct {
      bit            s, e, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_prdata;
      logic [NR-1:0] exp_strobe;
      int            chk_idx;
      logic [DW-1:0] chk_val;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit s, e, w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] xp, input logic [NR-1:0] xs, input int ci, input logic [DW-1:0] cv);
      vec_t v;
      v.s = s; v.e = e; v.w = w; v.a = a; v.d = d;
      v.exp_prdata = xp; v.exp_strobe = xs; v.chk_idx = ci; v.chk_val = cv;
      vecs.push_back(v);
   endtask

   logic [31:0] addr_pool [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h6};

   initial begin
      // write 0x4 (2-cycle write), then read WR_COUNT
      add(1,0,1,32'h4,32'hA5A50001, 32'h0, 4'b0000, 1, 32'h0);
      add(1,1,1,32'h4,32'hA5A50001, 32'h0, 4'b0010, 1, 32'hA5A50001);
      add(0,0,0,32'h0,32'h0,        32'h0, 4'b0000, 1, 32'hA5A50001);
      add(1,0,0,32'h10,32'h0,       32'h0, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h10,32'h0,       32'h1, 4'b0000, 0, 32'h0);
      add(0,0,0,32'h0,32'h0,        32'h1, 4'b0000, 0, 32'h0);
      // read 0x4 with access held 3 cycles, then RD_COUNT
      add(1,0,0,32'h4,32'h0,        32'h1, 4'b0000, 1, 32'hA5A50001);
      add(1,1,0,32'h4,32'h0,        32'hA5A50001, 4'b0000, 1, 32'hA5A50001);
      add(1,1,0,32'h4,32'h0,        32'hA5A50001, 4'b0000, 1, 32'hA5A50001);
      add(1,1,0,32'h4,32'h0,        32'hA5A50001, 4'b0000, 1, 32'hA5A50001);
      add(0,0,0,32'h0,32'h0,        32'hA5A50001, 4'b0000, 1, 32'hA5A50001);
      add(1,0,0,32'h14,32'h0,       32'hA5A50001, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h14,32'h0,       32'h2, 4'b0000, 0, 32'h0);
      add(0,0,0,32'h0,32'h0,        32'h2, 4'b0000, 0, 32'h0);
      // unmapped read, misaligned read, write to RO WR_COUNT
      add(1,0,0,32'h40,32'h0,       32'h2, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h40,32'h0,       32'h0, 4'b0000, 0, 32'h0);
      add(1,0,0,32'h6,32'h0,        32'h0, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h6,32'h0,        32'h0, 4'b0000, 0, 32'h0);
      add(1,0,1,32'h10,32'hDEAD,    32'h0, 4'b0000, 0, 32'h0);
      add(1,1,1,32'h10,32'hDEAD,    32'h0, 4'b0000, 0, 32'h0);
      add(0,0,0,32'h0,32'h0,        32'h0, 4'b0000, 0, 32'h0);
      add(1,0,0,32'h18,32'h0,       32'h0, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h18,32'h0,       32'h3, 4'b0000, 0, 32'h0);
      add(0,0,0,32'h0,32'h0,        32'h3, 4'b0000, 0, 32'h0);
      add(1,0,0,32'h10,32'h0,       32'h3, 4'b0000, 0, 32'h0);
      add(1,1,0,32'h10,32'h0,       32'h1, 4'b0000, 0, 32'h0);
      add(0,0,0,32'h0,32'h0,        32'h1, 4'b0000, 0, 32'h0);
      // back-to-back writes with PSEL held
      add(1,0,1,32'h0,32'h11,       32'h1, 4'b0000, 0, 32'h0);
      add(1,1,1,32'h0,32'h11,       32'h1, 4'b0001, 0, 32'h11);
      add(1,0,1,32'hC,32'h33,       32'h1, 4'b0000, 0, 32'h11);
      add(1,1,1,32'hC,32'h33,       32'h1, 4'b1000, 3, 32'h33);
      add(0,0,0,32'h0,32'h0,        32'h1, 4'b0000, 3, 32'h33);
      add(1,0,0,32'h10,32'h0,       32'h1, 4'b0000, 0, 32'h11);
      add(1,1,0,32'h10,32'h0,       32'h3, 4'b0000, 0, 32'h11);
      add(0,0,0,32'h0,32'h0,        32'h3, 4'b0000, 0, 32'h11);
      // access without setup from idle
      add(1,1,1,32'h0,32'h77,       32'h3, 4'b0000, 0, 32'h11);
      add(0,0,0,32'h0,32'h0,        32'h3, 4'b0000, 0, 32'h11);
      add(1,0,0,32'h18,32'h0,       32'h3, 4'b0000, 0, 32'h11);
      add(1,1,0,32'h18,32'h0,       32'h4, 4'b0000, 0, 32'h11);
      add(0,0,0,32'h0,32'h0,        32'h4, 4'b0000, 0, 32'h11);
      // bus address/data changes during held access are ignored
      add(1,0,1,32'h8,32'h5,        32'h4, 4'b0000, 2, 32'h0);
      add(1,1,1,32'h8,32'h5,        32'h4, 4'b0100, 2, 32'h5);
      add(1,1,1,32'h0,32'h99,       32'h4, 4'b0000, 2, 32'h5);
      add(0,0,0,32'h0,32'h0,        32'h4, 4'b0000, 0, 32'h11);

      rst = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      model_reset();
      repeat (2) @(posedge apbClk);
      #1;
      check("rst_prdata", NR*DW'(PRDATA), '0);
      check("rst_reg_q", reg_q, '0);
      check("rst_strobe", NR*DW'(wr_strobe), '0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         cyc(vecs[i].s, vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d);
         check($sformatf("tbl%0d_prdata", i), NR*DW'(PRDATA), NR*DW'(vecs[i].exp_prdata));
         check($sformatf("tbl%0d_strobe", i), NR*DW'(wr_strobe), NR*DW'(vecs[i].exp_strobe));
         check($sformatf("tbl%0d_reg", i), NR*DW'(reg_q[vecs[i].chk_idx*DW +: DW]), NR*DW'(vecs[i].chk_val));
      end

      // reset asserted asynchronously while a write to 0x8 is in setup
      cyc(1, 0, 1, 32'h8, 32'hFF);
      #2 rst = 1'b1;
      #1;
      check("midrst_prdata", NR*DW'(PRDATA), '0);
      check("midrst_reg_q", reg_q, '0);
      check("midrst_strobe", NR*DW'(wr_strobe), '0);
      model_reset();
      PENABLE = 1'b1;
      @(posedge apbClk);
      #1 rst = 1'b0;
      check("midrst_hold_reg_q", reg_q, '0);
      cyc(0, 0, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 32'h10, 32'h0);
      cyc(1, 1, 0, 32'h10, 32'h0);
      check("midrst_wrcnt", NR*DW'(PRDATA), '0);
      cyc(1, 0, 1, 32'h8, 32'hFF);
      cyc(1, 1, 1, 32'h8, 32'hFF);
      check("post_rst_write", NR*DW'(reg_q[2*DW +: DW]), NR*DW'(32'hFF));
      check("post_rst_strobe", NR*DW'(wr_strobe), NR*DW'(4'b0100));
      cyc(0, 0, 0, 32'h0, 32'h0);

      // randomized traffic, mostly well-formed transfers with occasional protocol noise
      for (int n = 0; n < 3000; n++) begin
         bit s, e, w;
         logic [AW-1:0] a;
         s = ($urandom_range(0, 9) != 0);
         e = $urandom_range(0, 1) == 1;
         w = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(0, 255)) : addr_pool[$urandom_range(0, 8)];
         cyc(s, e, w, a, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
